// File: rtl/alu_ctrl_q.sv
// ALU control decoder: decodes (opcode, funct) beats into ALU control fields
// and queues them in a small FIFO with an illegal-encoding error counter.
module alu_ctrl_q #(
    parameter int ALU_OP_W  = 4,
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           insop,
    input  logic [5:0]           insfunc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [2:0]           cmp_mode,
    output logic                 use_imm,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          cmp_mode;
        logic                use_imm;
        logic                illegal;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              dec;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                full, push, pop;

    // Decode: anything not listed falls through to the illegal default.
    always_comb begin
        dec.alu_op   = ALU_OP_W'(4'd15);
        dec.cmp_mode = 3'd0;
        dec.use_imm  = 1'b0;
        dec.illegal  = 1'b1;
        case (insop)
            6'd0: begin
                dec.illegal = 1'b0;
                case (insfunc)
                    6'd0:    dec.alu_op = ALU_OP_W'(4'd7);
                    6'd2:    dec.alu_op = ALU_OP_W'(4'd6);
                    6'd40:   dec.alu_op = ALU_OP_W'(4'd0);
                    6'd41:   dec.alu_op = ALU_OP_W'(4'd8);
                    6'd42:   dec.alu_op = ALU_OP_W'(4'd1);
                    6'd43:   dec.alu_op = ALU_OP_W'(4'd9);
                    6'd44:   dec.alu_op = ALU_OP_W'(4'd2);
                    6'd45:   dec.alu_op = ALU_OP_W'(4'd3);
                    6'd46:   dec.alu_op = ALU_OP_W'(4'd4);
                    6'd47:   dec.alu_op = ALU_OP_W'(4'd5);
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'd3, 6'd4, 6'd30, 6'd31, 6'd32, 6'd33: begin
                dec.illegal = 1'b0;
                dec.alu_op  = ALU_OP_W'(4'd1);
                case (insop)
                    6'd3:    dec.cmp_mode = 3'd1;
                    6'd4:    dec.cmp_mode = 3'd2;
                    6'd30:   dec.cmp_mode = 3'd3;
                    6'd31:   dec.cmp_mode = 3'd4;
                    6'd32:   dec.cmp_mode = 3'd5;
                    default: dec.cmp_mode = 3'd6;
                endcase
            end
            6'd10, 6'd43, 6'd53: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_OP_W'(4'd0);
            end
            6'd14: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_OP_W'(4'd2);
            end
            6'd15: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_OP_W'(4'd3);
            end
            6'd16: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_OP_W'(4'd4);
            end
            default: ;
        endcase
    end

    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (push && dec.illegal && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage carries data only, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    assign alu_op   = out_valid ? mem_q[rd_ptr_q].alu_op   : '0;
    assign cmp_mode = out_valid ? mem_q[rd_ptr_q].cmp_mode : '0;
    assign use_imm  = out_valid ? mem_q[rd_ptr_q].use_imm  : 1'b0;
    assign illegal  = out_valid ? mem_q[rd_ptr_q].illegal  : 1'b0;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_q.sv
// Directed self-checking bench for alu_ctrl_q; a second instance with a
// 2-bit error counter shares all inputs to exercise counter saturation.
module tb_alu_ctrl_q;

    logic       clk, rst_n, flush, in_valid, out_ready;
    logic [5:0] insop, insfunc;
    logic       in_ready, out_valid, use_imm, illegal;
    logic [3:0] alu_op;
    logic [2:0] cmp_mode;
    logic [7:0] err_cnt;
    logic       d2_in_ready, d2_out_valid, d2_use_imm, d2_illegal;
    logic [3:0] d2_alu_op;
    logic [2:0] d2_cmp_mode;
    logic [1:0] d2_err_cnt;

    int checks = 0;
    int failures = 0;

    alu_ctrl_q #(.ALU_OP_W(4), .DEPTH(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .insop(insop), .insfunc(insfunc),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .cmp_mode(cmp_mode), .use_imm(use_imm), .illegal(illegal),
        .err_cnt(err_cnt)
    );

    alu_ctrl_q #(.ALU_OP_W(4), .DEPTH(2), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(d2_in_ready), .insop(insop), .insfunc(insfunc),
        .out_valid(d2_out_valid), .out_ready(out_ready), .alu_op(d2_alu_op),
        .cmp_mode(d2_cmp_mode), .use_imm(d2_use_imm), .illegal(d2_illegal),
        .err_cnt(d2_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        insop = 6'd0; insfunc = 6'd0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        insop = 6'd0; insfunc = 6'd0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (alu_op !== 4'd0 || cmp_mode !== 3'd0 || use_imm !== 1'b0 || illegal !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: alu_op=%0d cmp=%0d imm=%b ill=%b err=%0d required all 0",
                     alu_op, cmp_mode, use_imm, illegal, err_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rfmt();
        int fn [10] = '{0, 2, 40, 41, 42, 43, 44, 45, 46, 47};
        int op [10] = '{7, 6, 0, 8, 1, 9, 2, 3, 4, 5};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; insop = 6'd0; insfunc = 6'(fn[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || alu_op !== 4'(op[i]) || cmp_mode !== 3'd0 ||
                use_imm !== 1'b0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL rfmt_%0d: v=%b alu_op=%0d cmp=%0d imm=%b ill=%b required 1/%0d/0/0/0",
                         fn[i], out_valid, alu_op, cmp_mode, use_imm, illegal, op[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rfmt_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_itype();
        int opc [12] = '{3, 4, 30, 31, 32, 33, 10, 14, 15, 16, 43, 53};
        int aop [12] = '{1, 1, 1, 1, 1, 1, 0, 2, 3, 4, 0, 0};
        int cmp [12] = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
        int imm [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; insop = 6'(opc[i]); insfunc = 6'd13;
            tick();
            checks++;
            if (out_valid !== 1'b1 || alu_op !== 4'(aop[i]) || cmp_mode !== 3'(cmp[i]) ||
                use_imm !== 1'(imm[i]) || illegal !== 1'b0) begin
                failures++;
                $display("FAIL itype_%0d: v=%b alu_op=%0d cmp=%0d imm=%b ill=%b required 1/%0d/%0d/%0d/0",
                         opc[i], out_valid, alu_op, cmp_mode, use_imm, illegal, aop[i], cmp[i], imm[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; insop = 6'd0; insfunc = 6'd40;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || alu_op !== 4'd0) begin
            failures++;
            $display("FAIL bp_first: in_ready=%b v=%b alu_op=%0d required 1/1/0", in_ready, out_valid, alu_op);
        end
        insfunc = 6'd42;
        tick();
        checks++;
        if (in_ready !== 1'b0 || alu_op !== 4'd0) begin
            failures++;
            $display("FAIL bp_full: in_ready=%b alu_op=%0d required 0/0", in_ready, alu_op);
        end
        insfunc = 6'd44;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_passthru: in_ready=%b required 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || alu_op !== 4'd1) begin
            failures++;
            $display("FAIL bp_pop1: in_ready=%b v=%b alu_op=%0d required 1/1/1", in_ready, out_valid, alu_op);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 4'd2) begin
            failures++;
            $display("FAIL bp_pop2: v=%b alu_op=%0d required 1/2", out_valid, alu_op);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || alu_op !== 4'd0) begin
            failures++;
            $display("FAIL bp_empty: v=%b alu_op=%0d required 0/0", out_valid, alu_op);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; insop = 6'd7; insfunc = 6'd0;
        tick();
        checks++;
        if (illegal !== 1'b1 || alu_op !== 4'd15 || cmp_mode !== 3'd0 || use_imm !== 1'b0 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL ill_op7: ill=%b alu_op=%0d cmp=%0d imm=%b err=%0d required 1/15/0/0/1",
                     illegal, alu_op, cmp_mode, use_imm, err_cnt);
        end
        insop = 6'd0; insfunc = 6'd1;
        tick();
        checks++;
        if (illegal !== 1'b1 || alu_op !== 4'd15 || err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ill_funct1: ill=%b alu_op=%0d err=%0d required 1/15/2", illegal, alu_op, err_cnt);
        end
        insop = 6'd63;
        tick();
        insop = 6'd2;
        tick();
        insop = 6'd0; insfunc = 6'd63;
        tick();
        checks++;
        if (err_cnt !== 8'd5 || d2_err_cnt !== 2'd3) begin
            failures++;
            $display("FAIL ill_saturate: err=%0d err2=%0d required 5/3", err_cnt, d2_err_cnt);
        end
        insfunc = 6'd40;
        tick();
        checks++;
        if (illegal !== 1'b0 || err_cnt !== 8'd5 || d2_err_cnt !== 2'd3) begin
            failures++;
            $display("FAIL ill_legal_hold: ill=%b err=%0d err2=%0d required 0/5/3", illegal, err_cnt, d2_err_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; insop = 6'd10;
        tick();
        insop = 6'd14;
        tick();
        flush = 1'b1; insop = 6'd7; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL flush_clear: v=%b in_ready=%b err=%0d required 0/1/0", out_valid, in_ready, err_cnt);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; insop = 6'd16;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 4'd4 || illegal !== 1'b0 || use_imm !== 1'b1) begin
            failures++;
            $display("FAIL flush_next: v=%b alu_op=%0d ill=%b imm=%b required 1/4/0/1",
                     out_valid, alu_op, illegal, use_imm);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_single: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; insop = 6'd7;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL arst_pre: v=%b err=%0d required 1/1", out_valid, err_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || alu_op !== 4'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL arst_now: v=%b err=%0d alu_op=%0d ill=%b required 0/0/0/0",
                     out_valid, err_cnt, alu_op, illegal);
        end
        #1 rst_n = 1'b1;
        in_valid = 1'b1; insop = 6'd15;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_op !== 4'd3 || use_imm !== 1'b1 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL arst_after: v=%b alu_op=%0d imm=%b err=%0d required 1/3/1/0",
                     out_valid, alu_op, use_imm, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rfmt();
        test_itype();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
